sync_fifo_plus: RTL and testbench
=================================

// Module: sync_fifo_plus
// PURPOSE
//   Single-clock parametrised FIFO; next generation of the team's sync FIFO.
//   Adds first-word-fall-through (FWFT) mode, fill level and programmable almost-full/almost-empty flags.
//   Adds synchronous flush and sticky overflow/underflow error flags.
//   Used as the general buffering element between pipeline stages in the processor datapath.
// PARAMETERS
//   DATA_WIDTH  8   width of din/dout
//   DEPTH       16  number of entries; power of two, >= 2
//   FWFT        0   0 = standard read (data 1 cycle after rd_en); 1 = first-word-fall-through
//   AF_THRESH   12  almost_full when level >= AF_THRESH; range 1..DEPTH
//   AE_THRESH   2   almost_empty when level <= AE_THRESH; range 0..DEPTH-1
//   XILINX_SYN  0   1 = apply block-RAM style attribute to storage (FWFT=0 only)
// PORTS
//   clk           in   1             clock, all logic on rising edge
//   rst_n         in   1             asynchronous active-low reset
//   flush         in   1             synchronous clear of contents
//   wr_en         in   1             write request
//   din           in   DATA_WIDTH    write data
//   full          out  1             no free entry
//   almost_full   out  1             level >= AF_THRESH
//   rd_en         in   1             read request (FWFT: pop/acknowledge head word)
//   rd_valid      out  1             dout holds valid read data
//   dout          out  DATA_WIDTH    read data
//   empty         out  1             no stored entry
//   almost_empty  out  1             level <= AE_THRESH
//   level         out  $clog2(DEPTH)+1  entries stored
//   err_clr       in   1             clears ovf/udf
//   ovf           out  1             sticky: write attempted while full
//   udf           out  1             sticky: read attempted while empty
// BEHAVIOUR
//   - Reset (async assert, sync release) values:
//       full=0, almost_full=0, empty=1, almost_empty=1, level=0.
//       rd_valid=0, dout=0, ovf=0, udf=0; both pointers = 0.
//   - Pointers are ADDR_WIDTH+1 bits.
//       Wrap-around: full when low bits are equal and MSBs differ; empty when the pointers are equal.
//   - Write accept = wr_en & ~full & ~flush.
//       wr_en & full -> data dropped, ovf set next cycle.
//       A same-cycle read does NOT unblock a write while full.
//   - Read accept = rd_en & ~empty & ~flush.
//       rd_en & empty -> ignored, udf set next cycle.
//       A same-cycle write does NOT unblock a read while empty.
//   - Simultaneous accepted write and read: level unchanged; full/empty unchanged.
//   - Flags full, empty, almost_*, level: registered, computed from next-state level.
//       They update on the edge that accepts the operation.
//   - FWFT=0:
//       rd_valid=1 for exactly one cycle, on the cycle after an accepted read; dout registered.
//       dout holds its last value until the next accepted read.
//       Write-to-rd_valid minimum latency = 2 cycles (empty falls after write edge, rd_en accepted next edge).
//   - FWFT=1:
//       rd_valid = ~empty; dout = head entry (asynchronous read of storage).
//       rd_en pops the head entry; the next entry appears the same cycle the pointer moves.
//       Write-to-rd_valid latency = 1 cycle.
//   - flush has priority over wr_en/rd_en in the same cycle.
//       Effect next cycle: pointers=0, level=0, empty=1, full=0, rd_valid=0.
//       A write in the flush cycle is discarded without setting ovf.
//       dout, ovf and udf are NOT changed by flush.
//   - err_clr clears ovf/udf.
//       A new error event in the same cycle as err_clr wins: the flag stays set.
//   - Reset mid-operation discards all contents immediately; no partial read data is presented.
// STRUCTURE
//   - Package fifo_pkg: fifo_mode_e {FIFO_STD, FIFO_FWFT} and the localparam helper ptr_w(DEPTH).
//   - Sub-module fifo_mem (simple dual-port RAM: sync write; registered or async read selected by parameter).
//     Carries the XILINX_SYN ram_style attribute.
//   - Top: pointer, level and flag control, read output stage, error flags.
// TESTING (DATA_WIDTH=8, DEPTH=16, AF=12, AE=2; both FWFT settings)
//   1. Reset, write 0x00..0x0F back-to-back
//        -> full=1 after 16th write; almost_full from level 12; level=16.
//   2. 17th write (0xAA) while full
//        -> ovf=1, level stays 16; reading all 16 returns 0x00..0x0F, no 0xAA.
//   3. Read on empty FIFO
//        -> udf=1, rd_valid stays 0; pulse err_clr -> udf=0.
//   4. Wrap: 1024 random words, 70% write / 40% read, continuous
//        -> order preserved, zero mismatches.
//        -> level == writes - reads every cycle; full/empty never both 1.
//   5. Latency at level 0: write 0x5C at cycle N
//        -> FWFT=1: rd_valid, dout=0x5C at N+1.
//        -> FWFT=0: rd_en at N+1 gives rd_valid, dout=0x5C at N+2.
//   6. At level 8: flush with wr_en=1, rd_en=1
//        -> next cycle level=0, empty=1, rd_valid=0, ovf=udf=0; then write/read 0x33 -> 0x33.

Source files
------------

// File: rtl/sync_fifo_plus_pkg.sv
// -----------------------------------------------------------------------------
// fifo_pkg
//   Shared types and helpers for the sync_fifo_plus buffering element.
//   fifo_mode_e : read-port behaviour (standard registered read or FWFT).
//   ptr_w()     : pointer width for a given depth.
//                 The pointer carries one extra wrap bit so that full and
//                 empty can be told apart when the address bits match.
// -----------------------------------------------------------------------------
package fifo_pkg;

  typedef enum logic {
    FIFO_STD  = 1'b0,
    FIFO_FWFT = 1'b1
  } fifo_mode_e;

  function automatic int ptr_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/sync_fifo_plus_mem.sv
// -----------------------------------------------------------------------------
// fifo_mem
//   Simple dual-port storage for sync_fifo_plus.
//   Writes are synchronous.
//   The read port is either registered (FIFO_STD) or combinational
//   (FIFO_FWFT), chosen by the MODE parameter.
//   With XILINX_SYN=1 in FIFO_STD mode the array carries a block-RAM
//   ram_style attribute.
// Ports
//   clk        in   1           clock, rising edge
//   rst_n      in   1           async active-low reset of the read register
//   i_wr_en    in   1           write strobe
//   i_wr_addr  in   AW          write address
//   i_wr_data  in   DATA_WIDTH  write data
//   i_rd_en    in   1           read strobe (registered mode only)
//   i_rd_addr  in   AW          read address
//   o_rd_data  out  DATA_WIDTH  read data
// -----------------------------------------------------------------------------
module fifo_mem
  import fifo_pkg::*;
#(
  parameter int         DATA_WIDTH = 8,
  parameter int         DEPTH      = 16,
  parameter fifo_mode_e MODE       = FIFO_STD,
  parameter int         XILINX_SYN = 0,
  localparam int        AW         = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  i_wr_en,
  input  logic [AW-1:0]         i_wr_addr,
  input  logic [DATA_WIDTH-1:0] i_wr_data,
  input  logic                  i_rd_en,
  input  logic [AW-1:0]         i_rd_addr,
  output logic [DATA_WIDTH-1:0] o_rd_data
);

  localparam bit USE_BRAM = (XILINX_SYN != 0) && (MODE == FIFO_STD);

  logic [DATA_WIDTH-1:0] w_rd_word;

  // The attribute cannot be made conditional on a parameter.
  // The two storage flavours therefore live in separate generate branches.
  if (USE_BRAM) begin : g_bram
    (* ram_style = "block" *) logic [DATA_WIDTH-1:0] r_mem [DEPTH];

    always_ff @(posedge clk) begin
      if (i_wr_en) begin
        r_mem[i_wr_addr] <= i_wr_data;
      end
    end

    assign w_rd_word = r_mem[i_rd_addr];
  end else begin : g_plain
    logic [DATA_WIDTH-1:0] r_mem [DEPTH];

    always_ff @(posedge clk) begin
      if (i_wr_en) begin
        r_mem[i_wr_addr] <= i_wr_data;
      end
    end

    assign w_rd_word = r_mem[i_rd_addr];
  end

  if (MODE == FIFO_STD) begin : g_reg_rd
    logic [DATA_WIDTH-1:0] r_rd_data;

    // The read register only loads on an accepted read.
    // Between reads it keeps presenting the last word.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_rd_data <= '0;
      end else if (i_rd_en) begin
        r_rd_data <= w_rd_word;
      end
    end

    assign o_rd_data = r_rd_data;
  end else begin : g_async_rd
    logic w_unused;
    assign w_unused  = ^{i_rd_en, rst_n};
    assign o_rd_data = w_rd_word;
  end

endmodule

// File: rtl/sync_fifo_plus.sv
// -----------------------------------------------------------------------------
// sync_fifo_plus
//   Single-clock parametrised FIFO with:
//     - optional first-word-fall-through read
//     - fill level and almost-full / almost-empty flags
//     - synchronous flush
//     - sticky overflow / underflow flags
// Ports
//   clk           in   1           clock, rising edge
//   rst_n         in   1           asynchronous active-low reset
//   flush         in   1           synchronous clear of contents
//   wr_en         in   1           write request
//   din           in   DATA_WIDTH  write data
//   full          out  1           no free entry
//   almost_full   out  1           level >= AF_THRESH
//   rd_en         in   1           read request / FWFT pop
//   rd_valid      out  1           dout holds valid read data
//   dout          out  DATA_WIDTH  read data
//   empty         out  1           no stored entry
//   almost_empty  out  1           level <= AE_THRESH
//   level         out  AW+1        entries stored
//   err_clr       in   1           clears ovf/udf
//   ovf           out  1           sticky: write attempted while full
//   udf           out  1           sticky: read attempted while empty
// -----------------------------------------------------------------------------
module sync_fifo_plus
  import fifo_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 16,
  parameter int FWFT       = 0,
  parameter int AF_THRESH  = 12,
  parameter int AE_THRESH  = 2,
  parameter int XILINX_SYN = 0
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       flush,
  input  logic                       wr_en,
  input  logic [DATA_WIDTH-1:0]      din,
  output logic                       full,
  output logic                       almost_full,
  input  logic                       rd_en,
  output logic                       rd_valid,
  output logic [DATA_WIDTH-1:0]      dout,
  output logic                       empty,
  output logic                       almost_empty,
  output logic [$clog2(DEPTH):0]     level,
  input  logic                       err_clr,
  output logic                       ovf,
  output logic                       udf
);

  localparam int         AW     = $clog2(DEPTH);
  localparam int         PW     = ptr_w(DEPTH);
  localparam fifo_mode_e MODE   = (FWFT != 0) ? FIFO_FWFT : FIFO_STD;
  localparam logic [PW-1:0] AF_LVL = PW'(AF_THRESH);
  localparam logic [PW-1:0] AE_LVL = PW'(AE_THRESH);

  logic [PW-1:0] r_wr_ptr;
  logic [PW-1:0] r_rd_ptr;
  logic [PW-1:0] r_level;
  logic          r_full;
  logic          r_empty;
  logic          r_almost_full;
  logic          r_almost_empty;
  logic          r_ovf;
  logic          r_udf;

  logic          w_wr_acc;
  logic          w_rd_acc;
  logic          w_ovf_evt;
  logic          w_udf_evt;
  logic [PW-1:0] w_wr_ptr_nxt;
  logic [PW-1:0] w_rd_ptr_nxt;
  logic [PW-1:0] w_level_nxt;
  logic          w_full_nxt;
  logic          w_empty_nxt;

  // Acceptance is gated by the registered flags only.
  // A same-cycle pop never frees room for a push, and vice versa.
  // Flush overrides both requests and suppresses the error events.
  assign w_wr_acc  = wr_en & ~r_full  & ~flush;
  assign w_rd_acc  = rd_en & ~r_empty & ~flush;
  assign w_ovf_evt = wr_en &  r_full  & ~flush;
  assign w_udf_evt = rd_en &  r_empty & ~flush;

  // Next-state pointers.
  // The level is their modular difference, which the extra wrap bit keeps
  // unambiguous.
  always_comb begin
    w_wr_ptr_nxt = r_wr_ptr;
    w_rd_ptr_nxt = r_rd_ptr;
    if (flush) begin
      w_wr_ptr_nxt = '0;
      w_rd_ptr_nxt = '0;
    end else begin
      if (w_wr_acc) begin
        w_wr_ptr_nxt = r_wr_ptr + PW'(1);
      end
      if (w_rd_acc) begin
        w_rd_ptr_nxt = r_rd_ptr + PW'(1);
      end
    end
  end

  assign w_level_nxt = w_wr_ptr_nxt - w_rd_ptr_nxt;
  assign w_empty_nxt = (w_wr_ptr_nxt == w_rd_ptr_nxt);
  assign w_full_nxt  = (w_wr_ptr_nxt[AW-1:0] == w_rd_ptr_nxt[AW-1:0]) &&
                       (w_wr_ptr_nxt[AW] != w_rd_ptr_nxt[AW]);

  // Pointers and all status flags register the next-state values.
  // Each flag therefore changes on the very edge that accepts the operation.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr       <= '0;
      r_rd_ptr       <= '0;
      r_level        <= '0;
      r_full         <= 1'b0;
      r_empty        <= 1'b1;
      r_almost_full  <= 1'b0;
      r_almost_empty <= 1'b1;
    end else begin
      r_wr_ptr       <= w_wr_ptr_nxt;
      r_rd_ptr       <= w_rd_ptr_nxt;
      r_level        <= w_level_nxt;
      r_full         <= w_full_nxt;
      r_empty        <= w_empty_nxt;
      r_almost_full  <= (w_level_nxt >= AF_LVL);
      r_almost_empty <= (w_level_nxt <= AE_LVL);
    end
  end

  // Sticky error flags.
  // A fresh event in the clearing cycle wins over err_clr.
  // Flush leaves both flags untouched.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ovf <= 1'b0;
      r_udf <= 1'b0;
    end else begin
      r_ovf <= w_ovf_evt | (r_ovf & ~err_clr);
      r_udf <= w_udf_evt | (r_udf & ~err_clr);
    end
  end

  fifo_mem #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH),
    .MODE       (MODE),
    .XILINX_SYN (XILINX_SYN)
  ) u_mem (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_wr_en    (w_wr_acc),
    .i_wr_addr  (r_wr_ptr[AW-1:0]),
    .i_wr_data  (din),
    .i_rd_en    (w_rd_acc),
    .i_rd_addr  (r_rd_ptr[AW-1:0]),
    .o_rd_data  (dout)
  );

  if (MODE == FIFO_STD) begin : g_std_valid
    logic r_rd_valid;

    // One-cycle strobe marking the word just loaded into the read register.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_rd_valid <= 1'b0;
      end else begin
        r_rd_valid <= w_rd_acc;
      end
    end

    assign rd_valid = r_rd_valid;
  end else begin : g_fwft_valid
    // The head entry is always on dout, so it is valid whenever anything is
    // stored.
    assign rd_valid = ~r_empty;
  end

  assign full         = r_full;
  assign empty        = r_empty;
  assign almost_full  = r_almost_full;
  assign almost_empty = r_almost_empty;
  assign level        = r_level;
  assign ovf          = r_ovf;
  assign udf          = r_udf;

endmodule

// File: tb/tb_sync_fifo_plus.sv
// -----------------------------------------------------------------------------
// tb_sync_fifo_plus
//   Drives one standard-read and one FWFT instance with identical stimulus.
//   Expected behaviour comes from a queue-based reference model.
// -----------------------------------------------------------------------------
module tb_sync_fifo_plus;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       flush, wrEn, rdEn, errClr;
  logic [7:0] din;

  logic       sFull, sAf, sEmpty, sAe, sValid, sOvf, sUdf;
  logic [7:0] sDout;
  logic [4:0] sLevel;
  logic       fFull, fAf, fEmpty, fAe, fValid, fOvf, fUdf;
  logic [7:0] fDout;
  logic [4:0] fLevel;

  int checks = 0;
  int errors = 0;

  // Reference model state
  logic [7:0] mq[$];
  bit         mOvf, mUdf, mValid;
  logic [7:0] mDout;
  int         nWrites, nReads;

  typedef struct {
    bit         wr;
    bit         rd;
    bit         fl;
    bit         ec;
    logic [7:0] d;
    int         expLevel;
    bit         expEmpty;
    bit         expUdf;
    bit         expValid;
  } vec_t;

  vec_t tbl[11];

  always #5 clk = ~clk;

  sync_fifo_plus #(.DATA_WIDTH(8), .DEPTH(16), .FWFT(0), .AF_THRESH(12),
                   .AE_THRESH(2), .XILINX_SYN(0)) u_std (
    .clk(clk), .rst_n(rst_n), .flush(flush), .wr_en(wrEn), .din(din),
    .full(sFull), .almost_full(sAf), .rd_en(rdEn), .rd_valid(sValid),
    .dout(sDout), .empty(sEmpty), .almost_empty(sAe), .level(sLevel),
    .err_clr(errClr), .ovf(sOvf), .udf(sUdf));

  sync_fifo_plus #(.DATA_WIDTH(8), .DEPTH(16), .FWFT(1), .AF_THRESH(12),
                   .AE_THRESH(2), .XILINX_SYN(0)) u_fwft (
    .clk(clk), .rst_n(rst_n), .flush(flush), .wr_en(wrEn), .din(din),
    .full(fFull), .almost_full(fAf), .rd_en(rdEn), .rd_valid(fValid),
    .dout(fDout), .empty(fEmpty), .almost_empty(fAe), .level(fLevel),
    .err_clr(errClr), .ovf(fOvf), .udf(fUdf));

  function automatic void check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endfunction

  // Applies one cycle of inputs (called at a negedge), advances the model on
  // the posedge and returns at the following negedge.
  task automatic applyStimulus(input bit w, input logic [7:0] d, input bit r,
                               input bit f, input bit ec);
    bit wrAcc, rdAcc, ovfEvt, udfEvt;
    int sz;
    wrEn = w; din = d; rdEn = r; flush = f; errClr = ec;
    @(posedge clk);
    sz     = mq.size();
    wrAcc  = w && !f && (sz < 16);
    rdAcc  = r && !f && (sz > 0);
    ovfEvt = w && !f && (sz == 16);
    udfEvt = r && !f && (sz == 0);
    if (f) begin
      mq.delete();
      mValid = 1'b0;
    end else begin
      mValid = rdAcc;
      if (rdAcc) mDout = mq.pop_front();
      if (wrAcc) mq.push_back(d);
    end
    mOvf = ovfEvt || (mOvf && !ec);
    mUdf = udfEvt || (mUdf && !ec);
    if (wrAcc) nWrites++;
    if (rdAcc) nReads++;
    @(negedge clk);
  endtask

  task automatic checkOutput(input string tag);
    int sz;
    sz = mq.size();
    check({tag, " std level"}, int'(sLevel), sz);
    check({tag, " std full"},  int'(sFull),  int'(sz == 16));
    check({tag, " std empty"}, int'(sEmpty), int'(sz == 0));
    check({tag, " std af"},    int'(sAf),    int'(sz >= 12));
    check({tag, " std ae"},    int'(sAe),    int'(sz <= 2));
    check({tag, " std ovf"},   int'(sOvf),   int'(mOvf));
    check({tag, " std udf"},   int'(sUdf),   int'(mUdf));
    check({tag, " std valid"}, int'(sValid), int'(mValid));
    check({tag, " std dout"},  int'(sDout),  int'(mDout));
    check({tag, " std full&empty"}, int'(sFull && sEmpty), 0);
    check({tag, " fwft level"}, int'(fLevel), sz);
    check({tag, " fwft full"},  int'(fFull),  int'(sz == 16));
    check({tag, " fwft empty"}, int'(fEmpty), int'(sz == 0));
    check({tag, " fwft af"},    int'(fAf),    int'(sz >= 12));
    check({tag, " fwft ae"},    int'(fAe),    int'(sz <= 2));
    check({tag, " fwft ovf"},   int'(fOvf),   int'(mOvf));
    check({tag, " fwft udf"},   int'(fUdf),   int'(mUdf));
    check({tag, " fwft valid"}, int'(fValid), int'(sz > 0));
    if (sz > 0) check({tag, " fwft dout"}, int'(fDout), int'(mq[0]));
  endtask

  task automatic modelReset();
    mq.delete();
    mOvf = 1'b0; mUdf = 1'b0; mValid = 1'b0; mDout = 8'h00;
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    rst_n = 1'b0; flush = 0; wrEn = 0; rdEn = 0; errClr = 0; din = 8'h00;
    modelReset();
    nWrites = 0; nReads = 0;
    repeat (2) @(negedge clk);
    checkOutput("reset");
    rst_n = 1'b1;
    applyStimulus(0, 8'h00, 0, 0, 0);
    checkOutput("post-reset");

    // Table-driven short sequence from empty; expected values written by hand.
    tbl[0]  = '{1, 0, 0, 0, 8'h11, 1, 0, 0, 0};
    tbl[1]  = '{1, 0, 0, 0, 8'h22, 2, 0, 0, 0};
    tbl[2]  = '{1, 1, 0, 0, 8'h33, 2, 0, 0, 1};
    tbl[3]  = '{0, 1, 0, 0, 8'h00, 1, 0, 0, 1};
    tbl[4]  = '{0, 1, 0, 0, 8'h00, 0, 1, 0, 1};
    tbl[5]  = '{0, 1, 0, 0, 8'h00, 0, 1, 1, 0};
    tbl[6]  = '{0, 0, 0, 1, 8'h00, 0, 1, 0, 0};
    tbl[7]  = '{0, 1, 0, 1, 8'h00, 0, 1, 1, 0};
    tbl[8]  = '{0, 0, 0, 1, 8'h00, 0, 1, 0, 0};
    tbl[9]  = '{1, 0, 1, 0, 8'h44, 0, 1, 0, 0};
    tbl[10] = '{1, 0, 0, 0, 8'h55, 1, 0, 0, 0};
    for (int i = 0; i < 11; i++) begin
      applyStimulus(tbl[i].wr, tbl[i].d, tbl[i].rd, tbl[i].fl, tbl[i].ec);
      check($sformatf("tbl%0d level", i), int'(sLevel), tbl[i].expLevel);
      check($sformatf("tbl%0d empty", i), int'(sEmpty), int'(tbl[i].expEmpty));
      check($sformatf("tbl%0d udf", i),   int'(sUdf),   int'(tbl[i].expUdf));
      check($sformatf("tbl%0d valid", i), int'(sValid), int'(tbl[i].expValid));
      check($sformatf("tbl%0d fwft udf", i), int'(fUdf), int'(tbl[i].expUdf));
      checkOutput($sformatf("tbl%0d", i));
    end
    applyStimulus(0, 8'h00, 0, 1, 0);
    checkOutput("flush0");

    // Fill 0x00..0x0F back to back.
    for (int i = 0; i < 16; i++) begin
      applyStimulus(1, 8'(i), 0, 0, 0);
      checkOutput("fill");
      check("fill af", int'(sAf), int'(i >= 11));
    end
    check("fill full", int'(sFull), 1);
    check("fill level", int'(sLevel), 16);

    // Overflow: the dropped word must never come out.
    applyStimulus(1, 8'hAA, 0, 0, 0);
    checkOutput("ovf");
    check("ovf flag", int'(sOvf), 1);
    check("ovf level", int'(fLevel), 16);
    for (int i = 0; i < 16; i++) begin
      if (i < 16) check("drain fwft head", int'(fDout), i);
      applyStimulus(0, 8'h00, 1, 0, 0);
      checkOutput("drain");
      check("drain std dout", int'(sDout), i);
    end
    applyStimulus(0, 8'h00, 0, 0, 1);
    checkOutput("ovf clr");

    // Underflow on empty, then clear.
    applyStimulus(0, 8'h00, 1, 0, 0);
    checkOutput("udf");
    check("udf flag", int'(sUdf), 1);
    check("udf valid", int'(sValid), 0);
    applyStimulus(0, 8'h00, 0, 0, 1);
    checkOutput("udf clr");
    check("udf cleared", int'(fUdf), 0);

    // Latency from level 0.
    applyStimulus(1, 8'h5C, 0, 0, 0);
    checkOutput("lat wr");
    check("lat fwft valid", int'(fValid), 1);
    check("lat fwft dout", int'(fDout), 8'h5C);
    check("lat std valid", int'(sValid), 0);
    applyStimulus(0, 8'h00, 1, 0, 0);
    checkOutput("lat rd");
    check("lat std valid2", int'(sValid), 1);
    check("lat std dout", int'(sDout), 8'h5C);

    // Flush at level 8 with both requests high.
    for (int i = 0; i < 8; i++) applyStimulus(1, 8'(8'hA0 + i), 0, 0, 0);
    checkOutput("pre-flush");
    applyStimulus(1, 8'hEE, 1, 1, 0);
    checkOutput("flush");
    check("flush level", int'(sLevel), 0);
    check("flush fwft valid", int'(fValid), 0);
    check("flush ovf", int'(sOvf), 0);
    check("flush udf", int'(fUdf), 0);
    applyStimulus(1, 8'h33, 0, 0, 0);
    checkOutput("post-flush wr");
    check("post-flush fwft dout", int'(fDout), 8'h33);
    applyStimulus(0, 8'h00, 1, 0, 0);
    checkOutput("post-flush rd");
    check("post-flush std dout", int'(sDout), 8'h33);

    // Random traffic: 70% write / 40% read until 1024 words accepted.
    nWrites = 0; nReads = 0;
    for (int cyc = 0; cyc < 6000 && nWrites < 1024; cyc++) begin
      applyStimulus($urandom_range(0, 99) < 70, 8'($urandom_range(0, 255)),
                    $urandom_range(0, 99) < 40, 0, 0);
      checkOutput("rand");
      check("rand level", int'(sLevel), nWrites - nReads);
    end
    check("rand writes done", int'(nWrites >= 1024), 1);
    for (int cyc = 0; cyc < 40 && mq.size() > 0; cyc++) begin
      applyStimulus(0, 8'h00, 1, 0, 0);
      checkOutput("rand drain");
    end
    check("rand drained", int'(sEmpty), 1);
    applyStimulus(0, 8'h00, 0, 0, 1);
    checkOutput("rand clr");

    // Reset in the middle of operation.
    for (int i = 0; i < 5; i++) applyStimulus(1, 8'(8'h70 + i), 0, 0, 0);
    applyStimulus(0, 8'h00, 1, 0, 0);
    checkOutput("pre-reset");
    #2 rst_n = 1'b0;
    #1;
    modelReset();
    checkOutput("async reset");
    @(negedge clk);
    rst_n = 1'b1;
    applyStimulus(0, 8'h00, 0, 0, 0);
    checkOutput("reset release");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
